// File: rtl/wavepool_issue_arbiter_if.sv
// Handshake bundle between the wavepool slots, the issue arbiter and decode.
// The slave side is the arbiter; the master side is the wavepool/decode environment.
interface wavepool_issue_arbiter_if #(
  parameter int NUM_WF = 40,
  parameter int WFID_W = 6
);
  logic [NUM_WF-1:0] wf_ready;
  logic              decode_stall;
  logic              release_valid;
  logic [WFID_W-1:0] release_wfid;
  logic              flush_valid;
  logic [WFID_W-1:0] flush_wfid;
  logic              issue_valid;
  logic [WFID_W-1:0] issue_wfid;
  logic [NUM_WF-1:0] issue_pop;
  logic [NUM_WF-1:0] inflight;
  logic              idle;

  modport master (
    output wf_ready, decode_stall, release_valid, release_wfid, flush_valid, flush_wfid,
    input  issue_valid, issue_wfid, issue_pop, inflight, idle
  );

  modport slave (
    input  wf_ready, decode_stall, release_valid, release_wfid, flush_valid, flush_wfid,
    output issue_valid, issue_wfid, issue_pop, inflight, idle
  );
endinterface

// File: rtl/wavepool_issue_arbiter.sv
// Round-robin issue arbiter: grants at most one ready, not-in-flight wavefront per
// cycle and holds its ownership bit until decode releases or flushes it.
module wavepool_issue_arbiter #(
  parameter int NUM_WF = 40,
  parameter int WFID_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  wavepool_issue_arbiter_if.slave bus
);
  logic [NUM_WF-1:0]   inflight_r;
  logic [NUM_WF-1:0]   issue_pop_r;
  logic [WFID_W-1:0]   ptr_r;
  logic [WFID_W-1:0]   issue_wfid_r;
  logic                issue_valid_r;
  logic                idle_r;

  logic [NUM_WF-1:0]   rel_mask_s;
  logic [NUM_WF-1:0]   flush_mask_s;
  logic [NUM_WF-1:0]   elig_s;
  logic [2*NUM_WF-1:0] dbl_s;
  logic [NUM_WF-1:0]   rot_s;
  logic [NUM_WF-1:0]   grant_mask_s;
  logic [WFID_W:0]     off_s;
  logic [WFID_W:0]     sum_s;
  logic [WFID_W-1:0]   grant_id_s;
  logic [WFID_W-1:0]   ptr_next_s;
  logic                grant_s;

  // Decode release/flush ids into slot masks; ids at or above NUM_WF match nothing.
  always_comb begin
    rel_mask_s   = {NUM_WF{1'b0}};
    flush_mask_s = {NUM_WF{1'b0}};
    for (int k = 0; k < NUM_WF; k++) begin
      rel_mask_s[k]   = bus.release_valid && (bus.release_wfid == WFID_W'(k));
      flush_mask_s[k] = bus.flush_valid && (bus.flush_wfid == WFID_W'(k));
    end
    elig_s = bus.wf_ready & ~inflight_r & ~flush_mask_s;
  end

  // Rotate eligibility so bit 0 is the slot at ptr, then take the lowest set bit.
  always_comb begin
    dbl_s   = {elig_s, elig_s};
    rot_s   = NUM_WF'(dbl_s >> ptr_r);
    grant_s = 1'b0;
    off_s   = {(WFID_W+1){1'b0}};
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        grant_s = 1'b1;
        off_s   = (WFID_W+1)'(i);
      end else begin
        grant_s = grant_s;
        off_s   = off_s;
      end
    end
    if (bus.decode_stall) begin
      grant_s = 1'b0;
    end else begin
      grant_s = grant_s;
    end
  end

  // Map the rotated offset back to an absolute wfid and advance the pointer past it.
  always_comb begin
    sum_s = {1'b0, ptr_r} + off_s;
    if (sum_s >= (WFID_W+1)'(NUM_WF)) begin
      grant_id_s = WFID_W'(sum_s - (WFID_W+1)'(NUM_WF));
    end else begin
      grant_id_s = WFID_W'(sum_s);
    end
    if (!grant_s) begin
      ptr_next_s = ptr_r;
    end else if (grant_id_s == WFID_W'(NUM_WF - 1)) begin
      ptr_next_s = {WFID_W{1'b0}};
    end else begin
      ptr_next_s = grant_id_s + WFID_W'(1);
    end
    grant_mask_s = {NUM_WF{1'b0}};
    for (int k = 0; k < NUM_WF; k++) begin
      grant_mask_s[k] = grant_s && (grant_id_s == WFID_W'(k));
    end
  end

  // Ownership, pointer and registered issue outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_r    <= {NUM_WF{1'b0}};
      ptr_r         <= {WFID_W{1'b0}};
      issue_valid_r <= 1'b0;
      issue_wfid_r  <= {WFID_W{1'b0}};
      issue_pop_r   <= {NUM_WF{1'b0}};
      idle_r        <= 1'b1;
    end else begin
      inflight_r    <= (inflight_r & ~(rel_mask_s | flush_mask_s)) | grant_mask_s;
      ptr_r         <= ptr_next_s;
      issue_valid_r <= grant_s;
      issue_pop_r   <= grant_mask_s;
      if (grant_s) begin
        issue_wfid_r <= grant_id_s;
      end else begin
        issue_wfid_r <= issue_wfid_r;
      end
      idle_r <= (inflight_r == {NUM_WF{1'b0}}) && (bus.wf_ready == {NUM_WF{1'b0}});
    end
  end

  assign bus.issue_valid = issue_valid_r;
  assign bus.issue_wfid  = issue_wfid_r;
  assign bus.issue_pop   = issue_pop_r;
  assign bus.inflight    = inflight_r;
  assign bus.idle        = idle_r;
endmodule

// File: tb/tb_wavepool_issue_arbiter.sv
// Bench for wavepool_issue_arbiter: directed vector table, async-reset sequence,
// then randomized traffic against a slot-array reference model.
module tb_wavepool_issue_arbiter;
  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;
  localparam int NTBL   = 30;

  typedef logic [NUM_WF-1:0] mask_t;

  typedef struct {
    mask_t             ready;
    logic              stall;
    logic              rv;
    logic [WFID_W-1:0] rid;
    logic              fv;
    logic [WFID_W-1:0] fid;
    logic              ev;
    logic [WFID_W-1:0] ewf;
    mask_t             epop;
    mask_t             einf;
    logic              eidle;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  vec_t tbl [NTBL];

  bit   m_inf [NUM_WF];
  int   m_ptr;

  wavepool_issue_arbiter_if #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) bus ();

  wavepool_issue_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mask_t bitm(input int n);
    mask_t m;
    m    = {NUM_WF{1'b0}};
    m[n] = 1'b1;
    return m;
  endfunction

  function automatic vec_t mkv(input mask_t ready, input logic stall, input logic rv,
                               input int rid, input logic fv, input int fid,
                               input logic ev, input int ewf, input mask_t epop,
                               input mask_t einf, input logic eidle);
    vec_t v;
    v.ready = ready; v.stall = stall;
    v.rv = rv; v.rid = WFID_W'(rid);
    v.fv = fv; v.fid = WFID_W'(fid);
    v.ev = ev; v.ewf = WFID_W'(ewf);
    v.epop = epop; v.einf = einf; v.eidle = eidle;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input mask_t ready, input logic stall, input logic rv,
                       input logic [WFID_W-1:0] rid, input logic fv,
                       input logic [WFID_W-1:0] fid);
    bus.wf_ready      = ready;
    bus.decode_stall  = stall;
    bus.release_valid = rv;
    bus.release_wfid  = rid;
    bus.flush_valid   = fv;
    bus.flush_wfid    = fid;
  endtask

  // Reference: search ptr..ptr+NUM_WF-1 modulo NUM_WF over the slot array.
  task automatic model_step(input mask_t ready, input logic stall, input logic rv,
                            input int rid, input logic fv, input int fid,
                            output logic ev, output int ewf, output mask_t epop,
                            output mask_t einf, output logic eidle);
    int g;
    int k;
    bit any;
    any = 1'b0;
    for (int j = 0; j < NUM_WF; j++) if (m_inf[j]) any = 1'b1;
    eidle = !any && (ready == {NUM_WF{1'b0}});
    g = -1;
    if (!stall) begin
      for (int j = 0; j < NUM_WF; j++) begin
        k = (m_ptr + j) % NUM_WF;
        if (g < 0 && ready[k] && !m_inf[k] && !(fv && fid == k)) g = k;
      end
    end
    if (rv && rid < NUM_WF) m_inf[rid] = 1'b0;
    if (fv && fid < NUM_WF) m_inf[fid] = 1'b0;
    epop = {NUM_WF{1'b0}};
    ev   = (g >= 0);
    ewf  = 0;
    if (g >= 0) begin
      m_inf[g] = 1'b1;
      m_ptr    = (g + 1) % NUM_WF;
      ewf      = g;
      epop     = bitm(g);
    end
    for (int j = 0; j < NUM_WF; j++) einf[j] = m_inf[j];
  endtask

  initial begin
    mask_t r3, r_rr, z;
    logic  ev, eidle;
    int    ewf, rid, fid, pick;
    mask_t epop, einf, rdy;
    logic  stall, rv, fv;
    int    q[$];

    n_vec = 0;
    n_err = 0;
    z     = {NUM_WF{1'b0}};
    r3    = bitm(3);
    r_rr  = bitm(0) | bitm(5) | bitm(39);

    tbl[0]  = mkv(r3, 0, 0, 0, 0, 0, 1, 3, r3, r3, 0);
    tbl[1]  = mkv(r3, 0, 0, 0, 0, 0, 0, 0, z, r3, 0);
    tbl[2]  = mkv(r3, 0, 1, 3, 0, 0, 0, 0, z, z, 0);
    tbl[3]  = mkv(r3, 0, 0, 0, 0, 0, 1, 3, r3, r3, 0);
    tbl[4]  = mkv(z, 0, 1, 3, 0, 0, 0, 0, z, z, 0);
    tbl[5]  = mkv(z, 0, 0, 0, 0, 0, 0, 0, z, z, 1);
    tbl[6]  = mkv(bitm(39), 0, 0, 0, 0, 0, 1, 39, bitm(39), bitm(39), 0);
    tbl[7]  = mkv(z, 0, 1, 39, 0, 0, 0, 0, z, z, 0);
    tbl[8]  = mkv(r_rr, 0, 0, 0, 0, 0, 1, 0, bitm(0), bitm(0), 0);
    tbl[9]  = mkv(r_rr, 0, 1, 0, 0, 0, 1, 5, bitm(5), bitm(5), 0);
    tbl[10] = mkv(r_rr, 0, 1, 5, 0, 0, 1, 39, bitm(39), bitm(39), 0);
    tbl[11] = mkv(r_rr, 0, 1, 39, 0, 0, 1, 0, bitm(0), bitm(0), 0);
    tbl[12] = mkv(z, 0, 1, 0, 0, 0, 0, 0, z, z, 0);
    for (int i = 13; i < 17; i++) tbl[i] = mkv(bitm(7), 1, 0, 0, 0, 0, 0, 0, z, z, 0);
    tbl[17] = mkv(bitm(7), 0, 0, 0, 0, 0, 1, 7, bitm(7), bitm(7), 0);
    tbl[18] = mkv(z, 0, 1, 7, 0, 0, 0, 0, z, z, 0);
    tbl[19] = mkv(bitm(1), 0, 0, 0, 0, 0, 1, 1, bitm(1), bitm(1), 0);
    tbl[20] = mkv(z, 0, 1, 1, 0, 0, 0, 0, z, z, 0);
    tbl[21] = mkv(bitm(2) | bitm(4), 0, 0, 0, 1, 2, 1, 4, bitm(4), bitm(4), 0);
    tbl[22] = mkv(bitm(2), 0, 0, 0, 0, 0, 1, 2, bitm(2), bitm(2) | bitm(4), 0);
    tbl[23] = mkv(z, 0, 1, 45, 0, 0, 0, 0, z, bitm(2) | bitm(4), 0);
    tbl[24] = mkv(z, 0, 1, 9, 0, 0, 0, 0, z, bitm(2) | bitm(4), 0);
    tbl[25] = mkv(bitm(1), 0, 0, 0, 0, 0, 1, 1, bitm(1), bitm(1) | bitm(2) | bitm(4), 0);
    tbl[26] = mkv(bitm(6), 0, 1, 1, 0, 0, 1, 6, bitm(6), bitm(2) | bitm(4) | bitm(6), 0);
    tbl[27] = mkv(z, 0, 1, 2, 1, 2, 0, 0, z, bitm(4) | bitm(6), 0);
    tbl[28] = mkv(z, 0, 1, 4, 1, 6, 0, 0, z, z, 0);
    tbl[29] = mkv(z, 0, 0, 0, 0, 0, 0, 0, z, z, 1);

    rst = 1'b0;
    drive(z, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset issue_valid", 64'(bus.issue_valid), 64'd0);
    check("reset issue_wfid", 64'(bus.issue_wfid), 64'd0);
    check("reset issue_pop", 64'(bus.issue_pop), 64'd0);
    check("reset inflight", 64'(bus.inflight), 64'd0);
    check("reset idle", 64'(bus.idle), 64'd1);
    rst = 1'b1;

    for (int i = 0; i < NTBL; i++) begin
      drive(tbl[i].ready, tbl[i].stall, tbl[i].rv, tbl[i].rid, tbl[i].fv, tbl[i].fid);
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d] issue_valid", i), 64'(bus.issue_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) check($sformatf("tbl[%0d] issue_wfid", i), 64'(bus.issue_wfid), 64'(tbl[i].ewf));
      check($sformatf("tbl[%0d] issue_pop", i), 64'(bus.issue_pop), 64'(tbl[i].epop));
      check($sformatf("tbl[%0d] inflight", i), 64'(bus.inflight), 64'(tbl[i].einf));
      check($sformatf("tbl[%0d] idle", i), 64'(bus.idle), 64'(tbl[i].eidle));
    end

    // Async reset mid-cycle while a grant is outstanding.
    drive(bitm(10), 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    @(posedge clk);
    #1;
    check("pre-reset issue_valid", 64'(bus.issue_valid), 64'd1);
    check("pre-reset inflight", 64'(bus.inflight), 64'(bitm(10)));
    #2;
    rst = 1'b0;
    #1;
    check("async issue_valid", 64'(bus.issue_valid), 64'd0);
    check("async issue_wfid", 64'(bus.issue_wfid), 64'd0);
    check("async issue_pop", 64'(bus.issue_pop), 64'd0);
    check("async inflight", 64'(bus.inflight), 64'd0);
    drive(z, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset idle", 64'(bus.idle), 64'd1);
    check("post-reset issue_valid", 64'(bus.issue_valid), 64'd0);

    for (int j = 0; j < NUM_WF; j++) m_inf[j] = 1'b0;
    m_ptr = 0;

    for (int c = 0; c < 3000; c++) begin
      rdy = NUM_WF'({$urandom, $urandom});
      if ($urandom_range(0, 1) == 0) rdy = rdy & NUM_WF'({$urandom, $urandom});
      if ($urandom_range(0, 15) == 0) rdy = z;
      stall = ($urandom_range(0, 4) == 0);
      q.delete();
      for (int j = 0; j < NUM_WF; j++) if (m_inf[j]) q.push_back(j);
      rv  = ($urandom_range(0, 1) == 0);
      rid = $urandom_range(0, 63);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        pick = $urandom_range(0, q.size() - 1);
        rid  = q[pick];
      end
      fv  = ($urandom_range(0, 5) == 0);
      fid = $urandom_range(0, NUM_WF - 1);
      if ($urandom_range(0, 7) == 0) fid = $urandom_range(0, 63);
      drive(rdy, stall, rv, WFID_W'(rid), fv, WFID_W'(fid));
      model_step(rdy, stall, rv, rid, fv, fid, ev, ewf, epop, einf, eidle);
      @(posedge clk);
      #1;
      check($sformatf("rnd[%0d] issue_valid", c), 64'(bus.issue_valid), 64'(ev));
      if (ev) check($sformatf("rnd[%0d] issue_wfid", c), 64'(bus.issue_wfid), 64'(ewf));
      check($sformatf("rnd[%0d] issue_pop", c), 64'(bus.issue_pop), 64'(epop));
      check($sformatf("rnd[%0d] inflight", c), 64'(bus.inflight), 64'(einf));
      check($sformatf("rnd[%0d] idle", c), 64'(bus.idle), 64'(eidle));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
